// File: rtl/log_pkg.sv
// Shared definitions for the logic-operation issuer.
// Contents: opcode constants, FSM state encoding, and log_ref(), a local model of the
// 64-bit logic unit. The issuer calls log_ref() only when LOG_RESULT_CHECK_EN is defined.
package log_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_NAND = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOTA = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [63:0] log_ref(input logic [2:0]  op,
                                            input logic [63:0] a,
                                            input logic [63:0] b);
        logic [63:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_NAND: r = ~(a & b);
            OP_OR:   r = a | b;
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            OP_NOTA: r = ~a;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/log_op_issuer_if.sv
// Bus bundle for log_op_issuer: command channel, logic-unit port and response channel.
// Modport master: the requester/environment side. It drives commands, lu_result and
// rsp_ready.
// Modport slave: the issuer itself.
interface log_op_issuer_if #(
    parameter int unsigned TAGW = 4
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [2:0]      cmd_op;
    logic [63:0]     cmd_opa;
    logic [63:0]     cmd_opb;
    logic [TAGW-1:0] cmd_tag;

    logic [2:0]      lu_op;
    logic [63:0]     lu_opa;
    logic [63:0]     lu_opb;
    logic [63:0]     lu_result;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [63:0]     rsp_data;
    logic [TAGW-1:0] rsp_tag;
    logic            rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_opa, cmd_opb, cmd_tag, lu_result, rsp_ready,
        input  cmd_ready, lu_op, lu_opa, lu_opb, rsp_valid, rsp_data, rsp_tag, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_opa, cmd_opb, cmd_tag, lu_result, rsp_ready,
        output cmd_ready, lu_op, lu_opa, lu_opb, rsp_valid, rsp_data, rsp_tag, rsp_err
    );
endinterface

// File: rtl/log_cmd_fifo.sv
// Synchronous command FIFO with DEPTH entries (power of 2, >= 2) of WIDTH bits.
// Ports:
//   clk, rst_n   clock; synchronous active-low reset (empties the FIFO)
//   push, wdata  write request/data; ignored when full
//   pop          read request; ignored when empty; rdata shows the head combinationally
//   full, empty, count  occupancy status
module log_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset; only entries behind valid pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/log_op_issuer.sv
// Requester-side front end for the 64-bit integer logic unit.
// Buffers tagged commands in log_cmd_fifo and issues them one at a time. It waits LAT
// cycles, captures lu_result, and returns the result in order with its tag.
// Ports:
//   clk, rst_n  clock; synchronous active-low reset
//   bus         log_op_issuer_if.slave: cmd_*, lu_*, rsp_* channels
//   busy        FSM not idle or commands queued
//   chk_fail    (only with LOG_RESULT_CHECK_EN) sticky lu_result mismatch flag
// Optional feature macro: LOG_RESULT_CHECK_EN. When it is defined, each lu_result is
// compared against a local log_ref() model. A mismatch sets rsp_err and the sticky
// chk_fail.
module log_op_issuer
    import log_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAGW  = 4,
    parameter int unsigned LAT   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    log_op_issuer_if.slave bus,
    output logic          busy
`ifdef LOG_RESULT_CHECK_EN
    ,
    output logic          chk_fail
`endif
);
    localparam int unsigned FW = 3 + 64 + 64 + TAGW;
    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;
    // Counter runs 0..LAT-1; the result is sampled on the edge that completes LAT cycles.
    localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

    logic [FW-1:0]         fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                  pop;

    logic [2:0]            head_op;
    logic [63:0]           head_opa;
    logic [63:0]           head_opb;
    logic [TAGW-1:0]       head_tag;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic [2:0]            op_q;
    logic [63:0]           opa_q;
    logic [63:0]           opb_q;
    logic [TAGW-1:0]       tag_q;
    logic [63:0]           rsp_data_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
`ifdef LOG_RESULT_CHECK_EN
    logic                  chk_fail_q;
`endif

    log_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.cmd_valid),
        .wdata ({bus.cmd_op, bus.cmd_opa, bus.cmd_opb, bus.cmd_tag}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign {head_op, head_opa, head_opb, head_tag} = fifo_rdata;

    // Pop from IDLE, or chain straight into the next command on a response handshake.
    assign pop = !fifo_empty &&
                 ((state_q == IDLE) || ((state_q == DONE) && bus.rsp_ready));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            tag_q       <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
`ifdef LOG_RESULT_CHECK_EN
            chk_fail_q  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                ISSUE: begin
                    if (cnt_q == CNT_LAST) begin
                        rsp_data_q  <= bus.lu_result;
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
`ifdef LOG_RESULT_CHECK_EN
                        if (bus.lu_result != log_ref(op_q, opa_q, opb_q)) begin
                            rsp_err_q  <= 1'b1;
                            chk_fail_q <= 1'b1;
                        end
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: ;
            endcase

            // A pop overrides the DONE->IDLE move above when more work is queued.
            if (pop) begin
                tag_q <= head_tag;
                cnt_q <= '0;
                if (head_op == OP_ILL) begin
                    // Illegal ops never reach the logic unit, so lu_* keep their old values.
                    rsp_data_q  <= '0;
                    rsp_err_q   <= 1'b1;
                    rsp_valid_q <= 1'b1;
                    state_q     <= DONE;
                end else begin
                    op_q      <= head_op;
                    opa_q     <= head_opa;
                    opb_q     <= head_opb;
                    rsp_err_q <= 1'b0;
                    state_q   <= ISSUE;
                end
            end
        end
    end

    assign bus.cmd_ready = !fifo_full;
    assign bus.lu_op     = op_q;
    assign bus.lu_opa    = opa_q;
    assign bus.lu_opb    = opb_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_tag   = tag_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy          = (state_q != IDLE) || (fifo_count != '0);
`ifdef LOG_RESULT_CHECK_EN
    assign chk_fail      = chk_fail_q;
`endif

endmodule

// File: tb/tb_log_op_issuer.sv
// Directed self-checking bench for log_op_issuer (DEPTH=4, TAGW=4, LAT=1).
// The logic unit is modelled combinationally from lu_*. lu_force_zero can pin its
// result to 0. Expected results are hand-computed constants.
module tb_log_op_issuer;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAGW  = 4;
    localparam int unsigned LAT   = 1;

    localparam logic [63:0] A1 = 64'hFFFF_0000_FFFF_0000;
    localparam logic [63:0] B1 = 64'h0F0F_0F0F_0F0F_0F0F;
    localparam logic [63:0] A  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] B  = 64'hFF00_FF00_FF00_FF00;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    logic lu_force_zero;
`ifdef LOG_RESULT_CHECK_EN
    logic chk_fail;
`endif
    int   n_vec  = 0;
    int   n_miss = 0;

    log_op_issuer_if #(.TAGW(TAGW)) bus ();

    always #5 clk = ~clk;

    function automatic logic [63:0] lu_model(input logic [2:0]  op,
                                             input logic [63:0] a,
                                             input logic [63:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return ~(a & b);
            3'd2:    return a | b;
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return 64'hDEAD_BEEF_DEAD_BEEF;
        endcase
    endfunction

    assign bus.lu_result = lu_force_zero ? 64'd0 : lu_model(bus.lu_op, bus.lu_opa, bus.lu_opb);

    log_op_issuer #(
        .DEPTH (DEPTH),
        .TAGW  (TAGW),
        .LAT   (LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy)
`ifdef LOG_RESULT_CHECK_EN
        ,
        .chk_fail (chk_fail)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges after the accept edge until rsp_valid is seen, bounded.
    task automatic wait_rsp(output int n);
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [TAGW-1:0] tag);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_opa   = a;
        bus.cmd_opb   = b;
        bus.cmd_tag   = tag;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic ack();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic check_reset(input string ctx);
        check_eq({ctx, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
        check_eq({ctx, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        check_eq({ctx, "_rsp_data"},  bus.rsp_data, 64'd0);
        check_eq({ctx, "_rsp_tag"},   64'(bus.rsp_tag), 64'd0);
        check_eq({ctx, "_rsp_err"},   64'(bus.rsp_err), 64'd0);
        check_eq({ctx, "_lu_op"},     64'(bus.lu_op), 64'd0);
        check_eq({ctx, "_lu_opa"},    bus.lu_opa, 64'd0);
        check_eq({ctx, "_lu_opb"},    bus.lu_opb, 64'd0);
        check_eq({ctx, "_busy"},      64'(busy), 64'd0);
`ifdef LOG_RESULT_CHECK_EN
        check_eq({ctx, "_chk_fail"},  64'(chk_fail), 64'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]  ops  [5];
        logic [63:0] exps [5];
        int n;
        int seen;

        ops  = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6};
        exps = '{64'hFEFF_BAFF_76FF_32FF, 64'hFF23_FF67_FFAB_FFEF, 64'h00DC_0098_0054_0010,
                 64'h01DC_4598_8954_CD10, 64'hFEDC_BA98_7654_3210};

        rst_n         = 1'b0;
        lu_force_zero = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_opa   = '0;
        bus.cmd_opb   = '0;
        bus.cmd_tag   = '0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        check_reset("rst");
        rst_n = 1'b1;
        tick();

        // Single AND; rsp_valid appears after 1+LAT further edges (seen 2+LAT after accept).
        send(3'd0, A1, B1, 4'd3);
        check_eq("and_busy", 64'(busy), 64'd1);
        wait_rsp(n);
        check_eq("and_lat",  64'(n), 64'(1 + LAT));
        check_eq("and_data", bus.rsp_data, 64'h0F0F_0000_0F0F_0000);
        check_eq("and_tag",  64'(bus.rsp_tag), 64'd3);
        check_eq("and_err",  64'(bus.rsp_err), 64'd0);
        ack();
        check_eq("and_drop", 64'(bus.rsp_valid), 64'd0);
        check_eq("and_idle", 64'(busy), 64'd0);

        // Illegal op completes one edge after accept and leaves lu_* untouched.
        send(3'd7, A, B, 4'd5);
        wait_rsp(n);
        check_eq("ill_lat",  64'(n), 64'd1);
        check_eq("ill_data", bus.rsp_data, 64'd0);
        check_eq("ill_err",  64'(bus.rsp_err), 64'd1);
        check_eq("ill_tag",  64'(bus.rsp_tag), 64'd5);
        check_eq("ill_luop", 64'(bus.lu_op), 64'd0);
        check_eq("ill_luopa", bus.lu_opa, A1);
        check_eq("ill_luopb", bus.lu_opb, B1);
        ack();

        // Fill with rsp_ready low: five accepts, one lands in the FSM, four fill the FIFO.
        for (int k = 0; k < 5; k++) begin
            check_eq("fill_ready", 64'(bus.cmd_ready), 64'd1);
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = ops[k];
            bus.cmd_opa   = A;
            bus.cmd_opb   = B;
            bus.cmd_tag   = k[TAGW-1:0];
            tick();
        end
        check_eq("full_ready", 64'(bus.cmd_ready), 64'd0);
        bus.cmd_op  = 3'd0;
        bus.cmd_tag = 4'd9;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("full_hold", 64'(bus.cmd_ready), 64'd0);
        end
        bus.cmd_valid = 1'b0;
        check_eq("stall_valid", 64'(bus.rsp_valid), 64'd1);
        check_eq("stall_tag",   64'(bus.rsp_tag), 64'd0);
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_rsp(n);
            check_eq("drain_gap",  64'(n), (k == 0) ? 64'd0 : 64'(LAT));
            check_eq("drain_tag",  64'(bus.rsp_tag), 64'(k));
            check_eq("drain_data", bus.rsp_data, exps[k]);
            check_eq("drain_err",  64'(bus.rsp_err), 64'd0);
            tick();
        end
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.rsp_valid) seen++;
            tick();
        end
        check_eq("drain_extra", 64'(seen), 64'd0);
        check_eq("drain_busy",  64'(busy), 64'd0);
        bus.rsp_ready = 1'b0;

        // XOR with delayed rsp_ready: response fields must hold until the handshake.
        send(3'd4, A, B, 4'd6);
        wait_rsp(n);
        check_eq("xor_lat", 64'(n), 64'(1 + LAT));
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("xor_valid", 64'(bus.rsp_valid), 64'd1);
            check_eq("xor_data",  bus.rsp_data, 64'hFE23_BA67_76AB_32EF);
            check_eq("xor_tag",   64'(bus.rsp_tag), 64'd6);
            check_eq("xor_err",   64'(bus.rsp_err), 64'd0);
        end
        check_eq("xor_luop", 64'(bus.lu_op), 64'd4);
        ack();
        check_eq("xor_drop", 64'(bus.rsp_valid), 64'd0);

        // Reset while the second command is in ISSUE with two more queued.
        bus.rsp_ready = 1'b1;
        send(3'd0, A, B, 4'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 3'd5; bus.cmd_tag = 4'd2; tick();
        bus.cmd_op = 3'd2; bus.cmd_tag = 4'd3; tick();
        bus.cmd_op = 3'd4; bus.cmd_tag = 4'd4; tick();
        bus.cmd_valid = 1'b0;
        check_eq("mid_luop",  64'(bus.lu_op), 64'd5);
        check_eq("mid_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("mid_busy",  64'(busy), 64'd1);
        rst_n = 1'b0;
        tick();
        check_reset("midrst");
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.rsp_valid || busy) seen++;
        end
        check_eq("midrst_stale", 64'(seen), 64'd0);
        bus.rsp_ready = 1'b0;

`ifdef LOG_RESULT_CHECK_EN
        // A wrong lu_result raises rsp_err and the sticky chk_fail.
        lu_force_zero = 1'b1;
        send(3'd2, A, B, 4'd7);
        wait_rsp(n);
        lu_force_zero = 1'b0;
        check_eq("chk_err",  64'(bus.rsp_err), 64'd1);
        check_eq("chk_data", bus.rsp_data, 64'd0);
        check_eq("chk_fail", 64'(chk_fail), 64'd1);
        ack();
        send(3'd0, A, B, 4'd8);
        wait_rsp(n);
        check_eq("chk_ok_err",  64'(bus.rsp_err), 64'd0);
        check_eq("chk_ok_data", bus.rsp_data, 64'h0100_4500_8900_CD00);
        check_eq("chk_sticky",  64'(chk_fail), 64'd1);
        ack();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("chk_clear", 64'(chk_fail), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/log_op_issuer.md
Name: log_op_issuer

Overview:
- Requester-side front end for the 64-bit integer logic unit.
- Accepts tagged logic-operation commands over a valid/ready interface and buffers them in a small FIFO.
- Issues each command to the logic unit, waits a fixed latency, and captures the result.
- Returns the result with its tag over a valid/ready response interface, in order, one command in flight at a time.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- TAGW, 4, tag width in bits.
- LAT, 1, logic-unit latency in cycles from issue to result valid; minimum 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept a command; equals not-full.
- cmd_op  input  3  operation code: 000 and, 001 nand, 010 or, 011 nor, 100 xor, 101 xnor, 110 not-A, 111 illegal.
- cmd_opa  input  64  operand A.
- cmd_opb  input  64  operand B.
- cmd_tag  input  TAGW  requester tag, returned unchanged.
- lu_op  output  3  operation driven to the logic unit.
- lu_opa  output  64  operand A to the logic unit.
- lu_opb  output  64  operand B to the logic unit.
- lu_result  input  64  result from the logic unit.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_data  output  64  result.
- rsp_tag  output  TAGW  tag of the completed command.
- rsp_err  output  1  set for an illegal opcode; rsp_data is 0 in that case.
- busy  output  1  high when the FSM is not IDLE or the FIFO is non-empty.

Behaviour:
- Reset (rst_n low at a clock edge): FIFO emptied, FSM to IDLE, wait counter 0.
  - Outputs after reset: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_err=0, lu_op=0, lu_opa=0, lu_opb=0, busy=0.
  - Reset mid-operation discards all queued and in-flight commands; no response is produced for them.
- Command acceptance: a push occurs when cmd_valid and cmd_ready are both high. When full, cmd_ready=0 and no push occurs.
- Simultaneous push and pop on a full FIFO is not allowed; cmd_ready stays 0 while full.
- Simultaneous push and pop on a non-full FIFO is allowed. The count is unchanged and the pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head, register op/opa/opb/tag, drive the lu_* outputs, and go to ISSUE (legal op) or DONE (op=111, setting err=1, data=0).
  - ISSUE: lu_* are held stable; the counter counts LAT cycles. On the cycle the counter reaches LAT, sample lu_result into rsp_data, set rsp_valid=1, and go to DONE.
  - DONE: rsp_valid=1; the response fields are held stable until rsp_ready=1. On the handshake cycle, clear rsp_valid.
    - If the FIFO is non-empty, pop the next command in the same cycle and go directly to ISSUE or DONE.
    - Otherwise go to IDLE.
- Latency: a command accepted into an empty FIFO with the FSM in IDLE gives rsp_valid exactly 2+LAT cycles after the accept edge.
  - That is: push edge, pop/issue edge, LAT wait edges, then rsp_valid is asserted.
  - Illegal ops complete 2 cycles after the accept edge.
- lu_* hold their last issued values while the FSM is IDLE.
- Responses are returned strictly in command order. No tag reordering.
- rsp_ready held low stalls the FSM indefinitely. The FIFO keeps accepting commands until full.

Optional Feature:
- Macro: LOG_RESULT_CHECK_EN.
- Defined: the block computes the expected result locally from the registered op/opa/opb.
  - When sampling lu_result, any mismatch sets rsp_err=1. rsp_data still carries lu_result.
  - A sticky output chk_fail (1 bit) is added. It is set on the first mismatch and cleared only by reset.
- Undefined: no local compute, no chk_fail port; rsp_err reflects illegal opcodes only.

Decomposition:
- Shared package log_pkg:
  - opcode localparams: OP_AND, OP_NAND, OP_OR, OP_NOR, OP_XOR, OP_XNOR, OP_NOTA, OP_ILL.
  - FSM state encoding: IDLE, ISSUE, DONE.
  - a function log_ref(op, a, b) returning the 64-bit expected result, used by LOG_RESULT_CHECK_EN.
- One sub-module: log_cmd_fifo, a synchronous FIFO of width 3+64+64+TAGW with DEPTH entries and full/empty/count outputs.

Test Plan:
- Reset then single command: op=000, opa=FFFF0000FFFF0000, opb=0F0F0F0F0F0F0F0F, tag=3, LAT=1.
  - Expect rsp_valid 3 cycles after accept, rsp_data=0F0F00000F0F0000, tag=3, err=0.
- Illegal op=111, tag=5.
  - Expect rsp_valid 2 cycles after accept, rsp_data=0, rsp_err=1; lu_* unchanged from the previous issue.
- Fill the FIFO with 5 back-to-back commands (tags 0-4) while rsp_ready=0.
  - Expect cmd_ready=0 after the 4th accept into the queue (one command popped to the FSM).
  - Then raise rsp_ready: responses return in tag order 0..4, one per 1+LAT cycles.
- Assert rsp_ready only after a 5-cycle delay on op=100 (xor).
  - Expect rsp_data/rsp_tag/rsp_err stable throughout the wait, and rsp_valid dropping the cycle after the handshake.
- Pull rst_n low during ISSUE with 2 commands queued.
  - Expect all outputs at reset values the next cycle and no stale responses afterwards.
- With LOG_RESULT_CHECK_EN defined, force lu_result to 0 for an op=010 command with nonzero operands.
  - Expect rsp_err=1 and chk_fail=1, staying high until reset.
